// File: rtl/brief_pkg.sv
// Shared widths, keypoint record and FSM states for the BRIEF descriptor collector.
// The optional SCORE_THRESH_EN build macro is consumed by brief_desc_collector.
package brief_pkg;

    localparam int MAX_KP  = 100;
    localparam int DESC_W  = 256;
    localparam int COOR_W  = 10;
    localparam int SCORE_W = 8;
    localparam int CNT_W   = 7;

    // Slot counter value at which a frame is full.
    localparam logic [CNT_W-1:0] MAX_KP_CNT = CNT_W'(MAX_KP);

    // One stored keypoint.
    typedef struct packed {
        logic [COOR_W-1:0]  x;
        logic [COOR_W-1:0]  y;
        logic [DESC_W-1:0]  desc;
        logic [SCORE_W-1:0] score;
    } kp_t;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_FILL = 1'b1
    } state_t;

endpackage

// File: rtl/brief_desc_bank.sv
// One ping-pong bank: MAX_KP keypoint slots, one write port, one registered read port.
module brief_desc_bank
    import brief_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             wr_en,
    input  logic [CNT_W-1:0] wr_addr,
    input  kp_t              wr_data,
    input  logic             rd_en,
    input  logic [CNT_W-1:0] rd_addr,
    output kp_t              rd_data
);

    kp_t mem [MAX_KP];

    // Slot storage; deliberately not reset so it can map onto RAM.
    always_ff @(posedge i_clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Registered read; only the output register is cleared by reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/brief_desc_collector.sv
// Ping-pong receiver for the BRIEF descriptor stream. One bank fills with the
// current frame while the other presents the last sealed frame for random reads.
// Build macro SCORE_THRESH_EN adds i_score_thresh and drops low-score keypoints.
module brief_desc_collector
    import brief_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_start,
    input  logic               i_end,
    input  logic               i_flag,
    input  logic [COOR_W-1:0]  i_coor_x,
    input  logic [COOR_W-1:0]  i_coor_y,
    input  logic [DESC_W-1:0]  i_descriptor,
    input  logic [SCORE_W-1:0] i_score,
`ifdef SCORE_THRESH_EN
    input  logic [SCORE_W-1:0] i_score_thresh,
`endif
    input  logic               i_rd_en,
    input  logic [CNT_W-1:0]   i_rd_addr,
    input  logic               i_rd_release,
    output logic               o_rd_ready,
    output logic [CNT_W-1:0]   o_rd_count,
    output logic               o_rd_overflow,
    output logic               o_rd_valid,
    output logic [COOR_W-1:0]  o_rd_coor_x,
    output logic [COOR_W-1:0]  o_rd_coor_y,
    output logic [DESC_W-1:0]  o_rd_descriptor,
    output logic [SCORE_W-1:0] o_rd_score,
    output logic               o_frame_drop
);

    state_t           state;
    logic [CNT_W-1:0] wr_count;
    logic             wr_ovf;
    logic             wr_bank;   // bank being filled; the other one is the read bank
    logic             rd_hit;    // last read was in range, so bank data is shown
    logic             rd_sel;    // bank that served the last read

    logic             score_ok;
    logic             flag_ok;
    logic             in_fill;
    logic             seal;
    logic             cur_flag;
    logic             cur_wr;
    logic             cur_drop;
    logic             new_wr;
    logic [CNT_W-1:0] next_count;
    logic             next_ovf;
    logic             rd_free;
    logic             accept;
    logic             wr_en;
    logic [CNT_W-1:0] wr_addr;
    kp_t              wr_data;
    logic             rd_fire;
    logic             rd_in_range;
    kp_t              rd_data0;
    kp_t              rd_data1;
    kp_t              rd_kp;

`ifdef SCORE_THRESH_EN
    assign score_ok = (i_score >= i_score_thresh);
`else
    assign score_ok = 1'b1;
`endif

    assign flag_ok  = i_flag & score_ok;
    assign in_fill  = (state == S_FILL);
    assign seal     = in_fill & i_end;

    // A flag belongs to the running frame unless a bare start replaces that frame.
    assign cur_flag = in_fill & flag_ok & (i_end | ~i_start);
    assign cur_wr   = cur_flag & (wr_count < MAX_KP_CNT);
    assign cur_drop = cur_flag & ~cur_wr;
    // A flag arriving with a start that does not also seal lands in slot 0 of the new frame.
    assign new_wr   = flag_ok & i_start & ~seal;

    assign next_count = wr_count + CNT_W'(cur_wr);
    assign next_ovf   = wr_ovf | cur_drop;

    // The read bank is free if empty or released in this very cycle.
    assign rd_free = ~o_rd_ready | i_rd_release;
    assign accept  = seal & rd_free;

    assign wr_en   = cur_wr | new_wr;
    assign wr_addr = new_wr ? '0 : wr_count;
    assign wr_data = '{x: i_coor_x, y: i_coor_y, desc: i_descriptor, score: i_score};

    assign rd_fire     = i_rd_en & o_rd_ready;
    assign rd_in_range = (i_rd_addr < o_rd_count);

    brief_desc_bank u_bank0 (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .wr_en   (wr_en & ~wr_bank),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_en   (rd_fire & rd_in_range & wr_bank),
        .rd_addr (i_rd_addr),
        .rd_data (rd_data0)
    );

    brief_desc_bank u_bank1 (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .wr_en   (wr_en & wr_bank),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_en   (rd_fire & rd_in_range & ~wr_bank),
        .rd_addr (i_rd_addr),
        .rd_data (rd_data1)
    );

    assign rd_kp           = rd_sel ? rd_data1 : rd_data0;
    assign o_rd_coor_x     = rd_hit ? rd_kp.x     : '0;
    assign o_rd_coor_y     = rd_hit ? rd_kp.y     : '0;
    assign o_rd_descriptor = rd_hit ? rd_kp.desc  : '0;
    assign o_rd_score      = rd_hit ? rd_kp.score : '0;

    // Frame FSM: fill, seal into the read bank or drop, and reader release.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state         <= S_IDLE;
            wr_count      <= '0;
            wr_ovf        <= 1'b0;
            wr_bank       <= 1'b0;
            o_rd_ready    <= 1'b0;
            o_rd_count    <= '0;
            o_rd_overflow <= 1'b0;
            o_frame_drop  <= 1'b0;
        end else begin
            o_frame_drop <= 1'b0;

            if (i_start) begin
                state    <= S_FILL;
                wr_count <= new_wr ? CNT_W'(1) : '0;
                wr_ovf   <= 1'b0;
            end else if (seal) begin
                state    <= S_IDLE;
            end else if (in_fill) begin
                wr_count <= next_count;
                wr_ovf   <= next_ovf;
            end

            if (accept) begin
                o_rd_ready    <= 1'b1;
                o_rd_count    <= next_count;
                o_rd_overflow <= next_ovf;
                wr_bank       <= ~wr_bank;
            end else begin
                if (seal) begin
                    o_frame_drop <= 1'b1;
                end
                if (i_rd_release && o_rd_ready) begin
                    o_rd_ready    <= 1'b0;
                    o_rd_count    <= '0;
                    o_rd_overflow <= 1'b0;
                end
            end
        end
    end

    // Read response: valid one cycle after an accepted request, data zeroed when out of range.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_rd_valid <= 1'b0;
            rd_hit     <= 1'b0;
            rd_sel     <= 1'b0;
        end else begin
            o_rd_valid <= rd_fire;
            rd_hit     <= rd_fire & rd_in_range;
            rd_sel     <= ~wr_bank;
        end
    end

endmodule

// File: tb/tb_brief_desc_collector.sv
// Bench for brief_desc_collector: table vectors, directed corner sequences and
// random traffic, all checked against a queue-based frame model.
`timescale 1ns/1ps
module tb_brief_desc_collector;
    import brief_pkg::*;

    typedef struct packed {
        logic [COOR_W-1:0]  x;
        logic [COOR_W-1:0]  y;
        logic [DESC_W-1:0]  d;
        logic [SCORE_W-1:0] s;
    } rec_t;

    typedef struct {
        bit   s, e, f;
        rec_t kp;
        bit   re;
        logic [CNT_W-1:0] a;
        bit   r;
        bit   x_ready;
        int   x_count;
        bit   x_valid;
        bit   x_drop;
        rec_t x_data;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic               start = 0, fend = 0, flag = 0, rd_en = 0, rel = 0;
    logic [COOR_W-1:0]  cx = '0, cy = '0;
    logic [DESC_W-1:0]  desc = '0;
    logic [SCORE_W-1:0] score = '0, thresh = '0;
    logic [CNT_W-1:0]   rd_addr = '0;

    logic               rd_ready, rd_ovf, rd_valid, frame_drop;
    logic [CNT_W-1:0]   rd_count;
    logic [COOR_W-1:0]  rd_x, rd_y;
    logic [DESC_W-1:0]  rd_desc;
    logic [SCORE_W-1:0] rd_score;

    brief_desc_collector dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_start         (start),
        .i_end           (fend),
        .i_flag          (flag),
        .i_coor_x        (cx),
        .i_coor_y        (cy),
        .i_descriptor    (desc),
        .i_score         (score),
`ifdef SCORE_THRESH_EN
        .i_score_thresh  (thresh),
`endif
        .i_rd_en         (rd_en),
        .i_rd_addr       (rd_addr),
        .i_rd_release    (rel),
        .o_rd_ready      (rd_ready),
        .o_rd_count      (rd_count),
        .o_rd_overflow   (rd_ovf),
        .o_rd_valid      (rd_valid),
        .o_rd_coor_x     (rd_x),
        .o_rd_coor_y     (rd_y),
        .o_rd_descriptor (rd_desc),
        .o_rd_score      (rd_score),
        .o_frame_drop    (frame_drop)
    );

    int errors = 0;
    int checks = 0;

    // Model: frames as queues of records.
    rec_t cur_q[$];
    rec_t rd_q[$];
    bit   m_active, m_ovf_cur, m_ready, m_rd_ovf;
    bit   e_valid, e_drop;
    rec_t e_data;

    task automatic check(input string name, input logic [299:0] act, input logic [299:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void add_cur(input rec_t kp);
        if (cur_q.size() < MAX_KP) cur_q.push_back(kp);
        else m_ovf_cur = 1'b1;
    endfunction

    function automatic void model_clear();
        cur_q.delete();
        rd_q.delete();
        m_active = 0; m_ovf_cur = 0; m_ready = 0; m_rd_ovf = 0;
        e_valid = 0; e_drop = 0; e_data = '0;
    endfunction

    // Predict the outputs after the next clock edge from the current inputs.
    function automatic void model_step();
        rec_t kp;
        bit   fok, sealed, accepted;
        kp = '{x: cx, y: cy, d: desc, s: score};
        fok = flag && (score >= thresh);
        sealed = 0;
        accepted = 0;
        e_valid = rd_en && m_ready;
        e_data = '0;
        if (e_valid && int'(rd_addr) < rd_q.size()) e_data = rd_q[rd_addr];
        e_drop = 0;
        if (m_active && fend) begin
            sealed = 1;
            if (fok) add_cur(kp);
            if (!m_ready || rel) begin
                rd_q = cur_q;
                m_rd_ovf = m_ovf_cur;
                m_ready = 1;
                accepted = 1;
            end else begin
                e_drop = 1;
            end
            m_active = 0;
        end else if (m_active && !start && fok) begin
            add_cur(kp);
        end
        if (rel && m_ready && !accepted) begin
            m_ready = 0;
            rd_q.delete();
            m_rd_ovf = 0;
        end
        if (start) begin
            cur_q.delete();
            m_ovf_cur = 0;
            m_active = 1;
            if (fok && !sealed) add_cur(kp);
        end
    endfunction

    task automatic compare_all(input string tag);
        check({tag, ".ready"}, rd_ready, m_ready);
        check({tag, ".count"}, rd_count, rd_q.size());
        check({tag, ".ovf"},   rd_ovf, m_rd_ovf);
        check({tag, ".valid"}, rd_valid, e_valid);
        check({tag, ".drop"},  frame_drop, e_drop);
        check({tag, ".data"},  {rd_x, rd_y, rd_desc, rd_score}, e_data);
    endtask

    task automatic cycle(input string tag, input bit s, input bit e, input bit f, input rec_t kp,
                         input bit re, input logic [CNT_W-1:0] a, input bit r);
        start = s; fend = e; flag = f;
        cx = kp.x; cy = kp.y; desc = kp.d; score = kp.s;
        rd_en = re; rd_addr = a; rel = r;
        model_step();
        @(posedge clk);
        #1;
        compare_all(tag);
    endtask

    function automatic rec_t mk(input int i);
        rec_t k;
        k.x = COOR_W'(i);
        k.y = COOR_W'(i + 300);
        k.d = {8{32'(i * 32'h0101_0101 + 32'h1234)}};
        k.s = SCORE_W'(i + 1);
        return k;
    endfunction

    localparam rec_t Z = '0;
    vec_t vecs[8];
    rec_t kp_a, kp_b;

    initial begin
        kp_a = '{x: 10'd5,   y: 10'd7,   d: {8{32'hA5A5_0001}}, s: 8'd40};
        kp_b = '{x: 10'd600, y: 10'd470, d: {8{32'h5A5A_0002}}, s: 8'd90};
        //            s e f  kp    re a     r  ready cnt valid drop data
        vecs[0] = '{1,0,0, Z,    0, 7'd0, 0, 0, 0, 0, 0, Z};
        vecs[1] = '{0,0,1, kp_a, 0, 7'd0, 0, 0, 0, 0, 0, Z};
        vecs[2] = '{0,0,1, kp_b, 0, 7'd0, 0, 0, 0, 0, 0, Z};
        vecs[3] = '{0,1,0, Z,    0, 7'd0, 0, 1, 2, 0, 0, Z};
        vecs[4] = '{0,0,0, Z,    1, 7'd1, 0, 1, 2, 1, 0, kp_b};
        vecs[5] = '{0,0,0, Z,    1, 7'd0, 0, 1, 2, 1, 0, kp_a};
        vecs[6] = '{0,0,0, Z,    1, 7'd2, 0, 1, 2, 1, 0, Z};
        vecs[7] = '{0,0,0, Z,    0, 7'd0, 1, 0, 0, 0, 0, Z};

        // Reset state
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        compare_all("reset");
        rst_n = 1'b1;

        // Basic frame, table driven
        for (int i = 0; i < 8; i++) begin
            cycle($sformatf("vec%0d", i), vecs[i].s, vecs[i].e, vecs[i].f, vecs[i].kp,
                  vecs[i].re, vecs[i].a, vecs[i].r);
            check($sformatf("tbl%0d.ready", i), rd_ready, vecs[i].x_ready);
            check($sformatf("tbl%0d.count", i), rd_count, vecs[i].x_count);
            check($sformatf("tbl%0d.valid", i), rd_valid, vecs[i].x_valid);
            check($sformatf("tbl%0d.drop", i),  frame_drop, vecs[i].x_drop);
            check($sformatf("tbl%0d.data", i),  {rd_x, rd_y, rd_desc, rd_score}, vecs[i].x_data);
        end

        // Saturation: 105 flags, slot 99 holds the 100th keypoint
        cycle("sat.start", 1, 0, 0, Z, 0, 0, 0);
        for (int i = 0; i < 105; i++) cycle("sat.flag", 0, 0, 1, mk(i), 0, 0, 0);
        cycle("sat.end", 0, 1, 0, Z, 0, 0, 0);
        check("sat.count", rd_count, 100);
        check("sat.ovf", rd_ovf, 1);
        cycle("sat.rd99", 0, 0, 0, Z, 1, 7'd99, 0);
        check("sat.slot99", {rd_x, rd_y, rd_desc, rd_score}, mk(99));
        cycle("sat.rel", 0, 0, 0, Z, 0, 0, 1);

        // Reader holds frame 1; frame 2 is dropped
        cycle("hold.s1", 1, 0, 0, Z, 0, 0, 0);
        for (int i = 0; i < 3; i++) cycle("hold.f1", 0, 0, 1, mk(i + 10), 0, 0, 0);
        cycle("hold.e1", 0, 1, 0, Z, 0, 0, 0);
        cycle("hold.s2", 1, 0, 0, Z, 0, 0, 0);
        for (int i = 0; i < 2; i++) cycle("hold.f2", 0, 0, 1, mk(i + 20), 0, 0, 0);
        cycle("hold.e2", 0, 1, 0, Z, 0, 0, 0);
        check("hold.drop", frame_drop, 1);
        check("hold.count", rd_count, 3);
        cycle("hold.after", 0, 0, 0, Z, 0, 0, 0);
        check("hold.drop_once", frame_drop, 0);

        // Release coincident with seal
        cycle("rs.s", 1, 0, 0, Z, 0, 0, 0);
        for (int i = 0; i < 2; i++) cycle("rs.f", 0, 0, 1, mk(i + 30), 0, 0, 0);
        cycle("rs.end_rel", 0, 1, 0, Z, 0, 0, 1);
        check("rs.drop", frame_drop, 0);
        check("rs.ready", rd_ready, 1);
        check("rs.count", rd_count, 2);
        cycle("rs.rd1", 0, 0, 0, Z, 1, 7'd1, 0);
        check("rs.slot1", {rd_x, rd_y, rd_desc, rd_score}, mk(31));

        // Restart: end + start + flag seals 4 keypoints, new frame begins at 0
        cycle("rst.rel", 0, 0, 0, Z, 0, 0, 1);
        cycle("rst.s", 1, 0, 0, Z, 0, 0, 0);
        for (int i = 0; i < 3; i++) cycle("rst.f", 0, 0, 1, mk(i + 40), 0, 0, 0);
        cycle("rst.esf", 1, 1, 1, mk(77), 0, 0, 0);
        check("rst.count", rd_count, 4);
        cycle("rst.rd3", 0, 0, 0, Z, 1, 7'd3, 0);
        check("rst.slot3.x", rd_x, 77);
        cycle("rst.rel2", 0, 0, 0, Z, 0, 0, 1);
        cycle("rst.f2", 0, 0, 1, mk(50), 0, 0, 0);
        cycle("rst.e2", 0, 1, 0, Z, 0, 0, 0);
        check("rst.newcount", rd_count, 1);

        // Abandon: bare start mid-fill with a flag restarts at slot 0, no drop
        cycle("ab.s", 1, 0, 1, mk(60), 0, 0, 1);
        cycle("ab.f", 0, 0, 1, mk(61), 0, 0, 0);
        cycle("ab.s2", 1, 0, 1, mk(62), 0, 0, 0);
        check("ab.nodrop", frame_drop, 0);
        cycle("ab.e", 0, 1, 0, Z, 0, 0, 0);
        check("ab.count", rd_count, 1);
        cycle("ab.rd0", 0, 0, 0, Z, 1, 7'd0, 0);
        check("ab.slot0.x", rd_x, 62);

        // Reset mid-fill clears everything
        cycle("mr.s", 1, 0, 1, mk(70), 0, 0, 0);
        cycle("mr.f", 0, 0, 1, mk(71), 1, 7'd0, 0);
        rst_n = 1'b0;
        #2;
        check("mr.ready", rd_ready, 0);
        check("mr.count", rd_count, 0);
        check("mr.valid", rd_valid, 0);
        check("mr.data", {rd_x, rd_y, rd_desc, rd_score}, 0);
        check("mr.drop", frame_drop, 0);
        model_clear();
        start = 0; fend = 0; flag = 0; rd_en = 0; rel = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycle("mr.idle", 0, 0, 0, Z, 0, 0, 0);
        cycle("mr.end_idle", 0, 1, 1, mk(5), 0, 0, 0);
        check("mr.idle_end_ready", rd_ready, 0);

`ifdef SCORE_THRESH_EN
        // Score threshold
        thresh = 8'd50;
        cycle("th.s", 1, 0, 0, Z, 0, 0, 0);
        cycle("th.49", 0, 0, 1, '{x: 1, y: 1, d: '0, s: 49}, 0, 0, 0);
        cycle("th.50", 0, 0, 1, '{x: 2, y: 2, d: '0, s: 50}, 0, 0, 0);
        cycle("th.200", 0, 0, 1, '{x: 3, y: 3, d: '0, s: 200}, 0, 0, 0);
        cycle("th.e", 0, 1, 0, Z, 0, 0, 0);
        check("th.count", rd_count, 2);
        cycle("th.rd0", 0, 0, 0, Z, 1, 7'd0, 0);
        check("th.slot0.score", rd_score, 50);
        cycle("th.rel", 0, 0, 0, Z, 0, 0, 1);
        thresh = 8'd0;
`endif

        // Random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            rec_t k;
            k.x = COOR_W'($urandom);
            k.y = COOR_W'($urandom);
            k.d = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            k.s = SCORE_W'($urandom);
            cycle("rnd",
                  ($urandom_range(0, 99) < 3),
                  ($urandom_range(0, 99) < 4),
                  ($urandom_range(0, 99) < 60),
                  k,
                  ($urandom_range(0, 99) < 30),
                  CNT_W'($urandom_range(0, 40)),
                  ($urandom_range(0, 99) < 5));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
